// File: rtl/btn_evt_pkg.sv
// Shared types for the button event scheduler: event codes, channel state
// encoding and the index-width helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EV_SHORT        = 2'd0,
    EV_LONG         = 2'd1,
    EV_REPEAT       = 2'd2,
    EV_LONG_RELEASE = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } ch_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Small synchronous FIFO for {button, type} events; push and pop may coincide
// at any fill level, including full.
module btn_event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so outputs are clean out of reset.
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Classifies debounced button presses into SHORT/LONG/REPEAT/LONG_RELEASE
// events and serialises them through one round-robin arbitrated queue.
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int unsigned NUM_BTNS     = 4,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned IDXW        = idx_width(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_state,
  input  logic [NUM_BTNS-1:0] btn_down,
  input  logic [NUM_BTNS-1:0] btn_up,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [IDXW-1:0]     ev_btn,
  output logic [1:0]          ev_type,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int unsigned MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned CW   = $clog2(MAXT + 1);
  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned EW   = IDXW + 2;

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  logic [NUM_BTNS-1:0] emit;
  ev_type_e            emit_type [NUM_BTNS];

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    ch_state_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rel;
    logic          emit_c;
    ev_type_e      type_c;

    // A dropped level counts as a release so a missed up pulse is recovered.
    assign rel = btn_up[i] | ~btn_state[i];

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      emit_c = 1'b0;
      type_c = EV_SHORT;
      unique case (st_q)
        ST_IDLE: begin
          if (btn_down[i] && !btn_up[i]) begin
            st_d  = ST_HELD;
            cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (rel) begin
            emit_c = 1'b1;
            type_c = EV_SHORT;
            st_d   = ST_IDLE;
            cnt_d  = '0;
          end else if (tick) begin
            if (cnt_q == CW'(LONG_TICKS - 1)) begin
              emit_c = 1'b1;
              type_c = EV_LONG;
              st_d   = ST_LONG;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (rel) begin
            emit_c = 1'b1;
            type_c = EV_LONG_RELEASE;
            st_d   = ST_IDLE;
            cnt_d  = '0;
          end else if (tick) begin
            if (cnt_q == CW'(REPEAT_TICKS - 1)) begin
              emit_c = 1'b1;
              type_c = EV_REPEAT;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign emit[i]      = emit_c;
    assign emit_type[i] = type_c;
  end

  logic [NUM_BTNS-1:0] slot_full_q, slot_full_d;
  logic [1:0]          slot_type_q [NUM_BTNS];
  logic [1:0]          slot_type_d [NUM_BTNS];
  logic [IDXW-1:0]     ptr_q, grant_idx;
  logic                grant_valid, ovf_set;
  logic                fifo_full, fifo_empty, pop;
  logic [EW-1:0]       push_data, head_data;

  assign pop      = ev_valid & ev_ready;
  assign ev_valid = ~fifo_empty;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_BTNS; k++) begin
      int unsigned j;
      j = (32'(ptr_q) + k) % NUM_BTNS;
      if (!grant_valid && slot_full_q[j] && (!fifo_full || pop)) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(j);
      end
    end
  end

  assign push_data = {grant_idx, slot_type_q[grant_idx]};

  // A slot being granted this cycle is free to take a new event at the same edge.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_type_d = slot_type_q;
    ovf_set     = 1'b0;
    if (grant_valid) slot_full_d[grant_idx] = 1'b0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (emit[i]) begin
        if (slot_full_q[i] && !(grant_valid && (grant_idx == IDXW'(i)))) begin
          ovf_set = 1'b1;
        end else begin
          slot_full_d[i] = 1'b1;
          slot_type_d[i] = emit_type[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full_q <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) slot_type_q[i] <= 2'd0;
      ptr_q       <= '0;
      overflow    <= 1'b0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_type_q <= slot_type_d;
      if (grant_valid) begin
        ptr_q <= (grant_idx == IDXW'(NUM_BTNS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  btn_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_valid),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_btn  = head_data[EW-1:2];
  assign ev_type = head_data[1:0];

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: directed scenarios plus
// randomized overlapping presses checked against a per-channel event model.
module tb_button_event_scheduler;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int LT = 5;
  localparam int RT = 3;
  localparam int FD = 4;

  localparam int T_SHORT = 0;
  localparam int T_LONG  = 1;
  localparam int T_REP   = 2;
  localparam int T_LREL  = 3;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_state, btn_down, btn_up;
  logic          ev_valid, ev_ready, overflow, ovf_clr;
  logic [1:0]    ev_btn;
  logic [1:0]    ev_type;

  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;
  int obs_btn[$];
  int obs_typ[$];

  button_event_scheduler #(
    .NUM_BTNS     (NB),
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_state (btn_state),
    .btn_down  (btn_down),
    .btn_up    (btn_up),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_btn    (ev_btn),
    .ev_type   (ev_type),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      obs_btn.push_back(int'(ev_btn));
      obs_typ.push_back(int'(ev_type));
    end
  end

  // One clock; edges counts edges since reset release, a tick edge is edges % TD == 0.
  task automatic cycle();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    btn_state = '0;
    btn_down  = '0;
    btn_up    = '0;
    ev_ready  = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) cycle();
    rst   = 1'b1;
    edges = 0;
    obs_btn.delete();
    obs_typ.delete();
  endtask

  // Hold a button until nt ticks have been counted while held, then release.
  task automatic press_ticks(input int ch, input int nt);
    int n;
    n = 0;
    btn_down[ch]  = 1'b1;
    btn_state[ch] = 1'b1;
    cycle();
    btn_down[ch] = 1'b0;
    while (n < nt) begin
      cycle();
      if (edges % TD == 0) n++;
    end
    btn_up[ch]    = 1'b1;
    btn_state[ch] = 1'b0;
    cycle();
    btn_up[ch] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++;
    if (ev_btn !== 2'd0) begin n_errors++; $display("FAIL reset_btn: got %0d want 0", ev_btn); end
    n_checks++;
    if (ev_type !== 2'd0) begin n_errors++; $display("FAIL reset_type: got %0d want 0", ev_type); end
  endtask

  task automatic test_short();
    obs_btn.delete();
    obs_typ.delete();
    btn_down[0]  = 1'b1;
    btn_state[0] = 1'b1;
    cycle();
    btn_down[0] = 1'b0;
    for (int n = 0; n < 2; ) begin
      cycle();
      if (edges % TD == 0) n++;
    end
    btn_up[0]    = 1'b1;
    btn_state[0] = 1'b0;
    cycle();
    btn_up[0] = 1'b0;
    n_checks++;
    if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL short_early: got %b want 0", ev_valid); end
    cycle();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_btn !== 2'd0 || ev_type !== 2'(T_SHORT)) begin
      n_errors++;
      $display("FAIL short_head: got v=%b b=%0d t=%0d want v=1 b=0 t=0", ev_valid, ev_btn, ev_type);
    end
    cycle();
    n_checks++;
    if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL short_one_cycle: got %b want 0", ev_valid); end
    repeat (6) cycle();
    n_checks++;
    if (obs_btn.size() != 1) begin
      n_errors++; $display("FAIL short_count: got %0d want 1", obs_btn.size());
    end
  endtask

  task automatic test_long_repeat();
    int exp_t[4];
    exp_t = '{T_LONG, T_REP, T_REP, T_LREL};
    obs_btn.delete();
    obs_typ.delete();
    press_ticks(1, 12);
    repeat (10) cycle();
    n_checks++;
    if (obs_btn.size() != 4) begin
      n_errors++; $display("FAIL long_count: got %0d want 4", obs_btn.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_btn[k] != 1 || obs_typ[k] != exp_t[k]) begin
          n_errors++;
          $display("FAIL long_ev%0d: got b=%0d t=%0d want b=1 t=%0d", k, obs_btn[k], obs_typ[k],
                   exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    int exp_b[2];
    exp_b = '{0, 2};
    do_reset();
    btn_down  = 4'hF;
    btn_state = 4'hF;
    cycle();
    btn_down = '0;
    repeat (3) cycle();
    btn_up    = 4'hF;
    btn_state = '0;
    cycle();
    btn_up = '0;
    repeat (10) cycle();
    n_checks++;
    if (obs_btn.size() != 4) begin
      n_errors++; $display("FAIL arb4_count: got %0d want 4", obs_btn.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_btn[k] != k || obs_typ[k] != T_SHORT) begin
          n_errors++;
          $display("FAIL arb4_ev%0d: got b=%0d t=%0d want b=%0d t=0", k, obs_btn[k], obs_typ[k], k);
        end
      end
    end
    obs_btn.delete();
    obs_typ.delete();
    btn_down  = 4'b0101;
    btn_state = 4'b0101;
    cycle();
    btn_down = '0;
    repeat (2) cycle();
    btn_up    = 4'b0101;
    btn_state = '0;
    cycle();
    btn_up = '0;
    repeat (8) cycle();
    n_checks++;
    if (obs_btn.size() != 2) begin
      n_errors++; $display("FAIL arb2_count: got %0d want 2", obs_btn.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_btn[k] != exp_b[k]) begin
          n_errors++; $display("FAIL arb2_ev%0d: got b=%0d want b=%0d", k, obs_btn[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ev_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < NB; ch++) begin
        press_ticks(ch, 0);
        repeat (2) cycle();
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_before: got %b want 0", overflow); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_btn !== 2'd0 || ev_type !== 2'(T_SHORT)) begin
        n_errors++;
        $display("FAIL ovf_head_stable: got v=%b b=%0d t=%0d want v=1 b=0 t=0", ev_valid, ev_btn,
                 ev_type);
      end
      cycle();
    end
    press_ticks(0, 0);
    cycle();
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    ev_ready = 1'b1;
    repeat (15) cycle();
    n_checks++;
    if (obs_btn.size() != 8) begin
      n_errors++; $display("FAIL ovf_drain_count: got %0d want 8", obs_btn.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (obs_btn[k] != (k % NB) || obs_typ[k] != T_SHORT) begin
          n_errors++;
          $display("FAIL ovf_drain_ev%0d: got b=%0d t=%0d want b=%0d t=0", k, obs_btn[k],
                   obs_typ[k], k % NB);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_hold();
    int n;
    ev_ready     = 1'b0;
    btn_down[1]  = 1'b1;
    btn_state[1] = 1'b1;
    cycle();
    btn_down[1] = 1'b0;
    n = 0;
    while (n < LT + 1) begin
      cycle();
      if (edges % TD == 0) n++;
    end
    n_checks++;
    if (ev_valid !== 1'b1) begin n_errors++; $display("FAIL rmh_pre_valid: got %b want 1", ev_valid); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL rmh_async: got %b want 0", ev_valid); end
    repeat (2) cycle();
    rst      = 1'b1;
    edges    = 0;
    ev_ready = 1'b1;
    obs_btn.delete();
    obs_typ.delete();
    repeat (5) cycle();
    btn_up[1]    = 1'b1;
    btn_state[1] = 1'b0;
    cycle();
    btn_up[1] = 1'b0;
    repeat (8) cycle();
    n_checks++;
    if (obs_btn.size() != 0) begin
      n_errors++; $display("FAIL rmh_no_event: got %0d events want 0", obs_btn.size());
    end
    press_ticks(1, 1);
    repeat (6) cycle();
    n_checks++;
    if (obs_btn.size() != 1 || obs_btn[0] != 1 || obs_typ[0] != T_SHORT) begin
      n_errors++;
      $display("FAIL rmh_short: got %0d events want 1 {1,SHORT}", obs_btn.size());
    end
  endtask

  task automatic test_missed_up();
    obs_btn.delete();
    obs_typ.delete();
    btn_down[2]  = 1'b1;
    btn_state[2] = 1'b1;
    cycle();
    btn_down[2] = 1'b0;
    repeat (5) cycle();
    btn_state[2] = 1'b0;
    cycle();
    repeat (6) cycle();
    n_checks++;
    if (obs_btn.size() != 1 || obs_btn[0] != 2 || obs_typ[0] != T_SHORT) begin
      n_errors++;
      $display("FAIL missed_up: got %0d events want 1 {2,SHORT}", obs_btn.size());
    end
    obs_btn.delete();
    obs_typ.delete();
    btn_down[2] = 1'b1;
    btn_up[2]   = 1'b1;
    cycle();
    btn_down[2] = 1'b0;
    btn_up[2]   = 1'b0;
    repeat (8) cycle();
    n_checks++;
    if (obs_btn.size() != 0) begin
      n_errors++; $display("FAIL down_up_same: got %0d events want 0", obs_btn.size());
    end
  endtask

  // Two channels pressed with random overlap; releases land on tick edges.
  task automatic test_random();
    int st[NB], ln[NB], nt[NB], ph[NB];
    bit act[NB];
    int a, b;
    int exp_t[$];
    int got_t[$];
    for (int r = 0; r < 12; r++) begin
      obs_btn.delete();
      obs_typ.delete();
      a = $urandom_range(0, NB - 1);
      b = (a + $urandom_range(1, NB - 1)) % NB;
      for (int ch = 0; ch < NB; ch++) begin
        act[ch] = (ch == a) || (ch == b);
        st[ch]  = $urandom_range(0, 10);
        ln[ch]  = $urandom_range(1, 60);
        nt[ch]  = 0;
        ph[ch]  = 0;
      end
      for (int c = 0; c < 90; c++) begin
        for (int ch = 0; ch < NB; ch++) begin
          btn_down[ch] = 1'b0;
          btn_up[ch]   = 1'b0;
          if (act[ch] && ph[ch] == 0 && c == st[ch]) begin
            btn_down[ch]  = 1'b1;
            btn_state[ch] = 1'b1;
            ph[ch]        = 1;
          end else if (ph[ch] == 1 && c >= st[ch] + ln[ch] && ((edges + 1) % TD == 0)) begin
            btn_up[ch]    = 1'b1;
            btn_state[ch] = 1'b0;
            ph[ch]        = 2;
          end
        end
        ev_ready = ev_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cycle();
        for (int ch = 0; ch < NB; ch++) begin
          if (ph[ch] == 1 && !btn_down[ch] && (edges % TD == 0)) nt[ch]++;
        end
      end
      btn_down = '0;
      btn_up   = '0;
      ev_ready = 1'b1;
      repeat (30) cycle();
      for (int ch = 0; ch < NB; ch++) begin
        exp_t.delete();
        got_t.delete();
        if (act[ch]) begin
          if (nt[ch] < LT) begin
            exp_t.push_back(T_SHORT);
          end else begin
            exp_t.push_back(T_LONG);
            for (int k = 0; k < (nt[ch] - LT) / RT; k++) exp_t.push_back(T_REP);
            exp_t.push_back(T_LREL);
          end
        end
        for (int k = 0; k < obs_btn.size(); k++) begin
          if (obs_btn[k] == ch) got_t.push_back(obs_typ[k]);
        end
        n_checks++;
        if (got_t.size() != exp_t.size()) begin
          n_errors++;
          $display("FAIL rnd_r%0d_ch%0d_count: got %0d want %0d (ticks %0d)", r, ch, got_t.size(),
                   exp_t.size(), nt[ch]);
        end else begin
          for (int k = 0; k < exp_t.size(); k++) begin
            n_checks++;
            if (got_t[k] != exp_t[k]) begin
              n_errors++;
              $display("FAIL rnd_r%0d_ch%0d_ev%0d: got t=%0d want t=%0d", r, ch, k, got_t[k],
                       exp_t[k]);
            end
          end
        end
      end
      n_checks++;
      if (overflow !== 1'b0) begin
        n_errors++; $display("FAIL rnd_r%0d_ovf: got %b want 0", r, overflow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long_repeat();
    test_arbitration();
    test_overflow();
    test_reset_mid_hold();
    test_missed_up();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
